// File: rtl/reg_read_port.sv
// Register-file read port with a busy scoreboard, one-entry response register and stall counter.
// Optional write-back forwarding is enabled by defining REG_READ_BYPASS_EN.
module reg_read_port (
  input  logic          Clk,
  input  logic          Clr,
  input  logic [1023:0] Q,
  input  logic          Req_valid,
  output logic          Req_ready,
  input  logic [4:0]    Rs,
  input  logic [4:0]    Rt,
  input  logic          Iss_valid,
  input  logic [4:0]    Iss_rd,
  input  logic          Wb_valid,
  input  logic [4:0]    Wb_rd,
  input  logic [31:0]   Wb_data,
  output logic          Rsp_valid,
  input  logic          Rsp_ready,
  output logic [31:0]   A,
  output logic [31:0]   B,
  output logic [15:0]   Stall_cnt
);

`ifdef REG_READ_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic [31:0] busy_q, busy_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [15:0] stall_q, stall_d;
  logic        wb_hit_rs, wb_hit_rt;
  logic        haz_rs, haz_rt;
  logic        accept;

  // Register 0 reads as zero; a forwarded write-back wins over the stale file contents.
  function automatic logic [31:0] read_operand(input logic [4:0]    r,
                                               input logic          fwd,
                                               input logic [1023:0] q,
                                               input logic [31:0]   wd);
    if (r == 5'd0) return 32'h0;
    if (fwd)       return wd;
    return q[{r, 5'd0} +: 32];
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    wb_hit_rs = Wb_valid && (Wb_rd == Rs) && (Rs != 5'd0);
    wb_hit_rt = Wb_valid && (Wb_rd == Rt) && (Rt != 5'd0);

    // With forwarding a landing write cures the hazard; without it the write itself blocks the read.
    if (Bypass) begin
      haz_rs = (Rs != 5'd0) && busy_q[Rs] && !wb_hit_rs;
      haz_rt = (Rt != 5'd0) && busy_q[Rt] && !wb_hit_rt;
    end else begin
      haz_rs = (Rs != 5'd0) && (busy_q[Rs] || wb_hit_rs);
      haz_rt = (Rt != 5'd0) && (busy_q[Rt] || wb_hit_rt);
    end

    Req_ready = !Clr && !haz_rs && !haz_rt && (!rsp_valid_q || Rsp_ready);
    accept    = Req_valid && Req_ready;

    busy_d = busy_q;
    if (Wb_valid) busy_d[Wb_rd] = 1'b0;
    if (Iss_valid && (Iss_rd != 5'd0)) busy_d[Iss_rd] = 1'b1;
    busy_d[0] = 1'b0;

    rsp_valid_d = rsp_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      a_d         = read_operand(Rs, Bypass && wb_hit_rs, Q, Wb_data);
      b_d         = read_operand(Rt, Bypass && wb_hit_rt, Q, Wb_data);
    end else if (rsp_valid_q && Rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    stall_d = stall_q;
    if (Req_valid && !Req_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      busy_q      <= 32'h0;
      rsp_valid_q <= 1'b0;
      a_q         <= 32'h0;
      b_q         <= 32'h0;
      stall_q     <= 16'h0;
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      stall_q     <= stall_d;
    end
  end

  assign Rsp_valid = rsp_valid_q;
  assign A         = a_q;
  assign B         = b_q;
  assign Stall_cnt = stall_q;

endmodule

// File: tb/tb_reg_read_port.sv
// Directed bench for reg_read_port; expectations follow the build selected by REG_READ_BYPASS_EN.
module tb_reg_read_port;

  logic          Clk;
  logic          Clr;
  logic [1023:0] Q;
  logic          Req_valid;
  logic          Req_ready;
  logic [4:0]    Rs, Rt;
  logic          Iss_valid;
  logic [4:0]    Iss_rd;
  logic          Wb_valid;
  logic [4:0]    Wb_rd;
  logic [31:0]   Wb_data;
  logic          Rsp_valid;
  logic          Rsp_ready;
  logic [31:0]   A, B;
  logic [15:0]   Stall_cnt;

  int total = 0;
  int bad   = 0;
  int exp_stall;

  reg_read_port dut (
    .Clk(Clk), .Clr(Clr), .Q(Q),
    .Req_valid(Req_valid), .Req_ready(Req_ready), .Rs(Rs), .Rt(Rt),
    .Iss_valid(Iss_valid), .Iss_rd(Iss_rd),
    .Wb_valid(Wb_valid), .Wb_rd(Wb_rd), .Wb_data(Wb_data),
    .Rsp_valid(Rsp_valid), .Rsp_ready(Rsp_ready),
    .A(A), .B(B), .Stall_cnt(Stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Clr = 1'b1; Q = '0; Req_valid = 1'b0; Rs = 5'd0; Rt = 5'd0;
    Iss_valid = 1'b0; Iss_rd = 5'd0; Wb_valid = 1'b0; Wb_rd = 5'd0;
    Wb_data = 32'h0; Rsp_ready = 1'b1;
    Q[32*5 +: 32] = 32'h1234_5678;
    Q[32*9 +: 32] = 32'hDEAD_BEEF;
    Q[32*3 +: 32] = 32'h3333_3333;

    // Reset: request visible while Clr high must not be accepted.
    #1;
    Req_valid = 1'b1;
    #1 check("ready_in_clr", 32'(Req_ready), 32'd0);
    tick();
    Clr = 1'b0;
    check("rst_rsp_valid", 32'(Rsp_valid), 32'd0);
    check("rst_a", A, 32'h0);
    check("rst_b", B, 32'h0);
    check("rst_stall", 32'(Stall_cnt), 32'd0);

    // Request of r0/r0.
    #1 check("r0_ready", 32'(Req_ready), 32'd1);
    tick();
    check("r0_rsp_valid", 32'(Rsp_valid), 32'd1);
    check("r0_a", A, 32'h0);
    check("r0_b", B, 32'h0);
    check("r0_stall", 32'(Stall_cnt), 32'd0);

    // Plain read of r5/r9, back-to-back with the previous response.
    Rs = 5'd5; Rt = 5'd9;
    #1 check("rd59_ready", 32'(Req_ready), 32'd1);
    tick();
    check("rd59_a", A, 32'h1234_5678);
    check("rd59_b", B, 32'hDEAD_BEEF);
    check("rd59_rsp_valid", 32'(Rsp_valid), 32'd1);

    // Reserve r7, then stall on it for three cycles.
    Req_valid = 1'b0; Iss_valid = 1'b1; Iss_rd = 5'd7;
    tick();
    Iss_valid = 1'b0;
    check("drain_rsp_valid", 32'(Rsp_valid), 32'd0);
    Req_valid = 1'b1; Rs = 5'd7; Rt = 5'd0;
    #1 check("haz7_ready", 32'(Req_ready), 32'd0);
    tick(); tick(); tick();
    check("haz7_stall3", 32'(Stall_cnt), 32'd3);

    Wb_valid = 1'b1; Wb_rd = 5'd7; Wb_data = 32'hCAFE_0001;
`ifdef REG_READ_BYPASS_EN
    #1 check("wb7_ready_byp", 32'(Req_ready), 32'd1);
    tick();
    Wb_valid = 1'b0; Q[32*7 +: 32] = 32'hCAFE_0001;
    exp_stall = 3;
`else
    #1 check("wb7_ready_nobyp", 32'(Req_ready), 32'd0);
    tick();
    Wb_valid = 1'b0; Q[32*7 +: 32] = 32'hCAFE_0001;
    #1 check("q7_ready", 32'(Req_ready), 32'd1);
    tick();
    exp_stall = 4;
`endif
    check("r7_a", A, 32'hCAFE_0001);
    check("r7_b", B, 32'h0);
    check("r7_rsp_valid", 32'(Rsp_valid), 32'd1);
    check("r7_stall", 32'(Stall_cnt), 32'(exp_stall));

    // Backpressure: response held for four cycles.
    Rsp_ready = 1'b0; Rs = 5'd5; Rt = 5'd9;
    #1 check("bp_ready", 32'(Req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_a_hold", A, 32'hCAFE_0001);
      check("bp_rsp_hold", 32'(Rsp_valid), 32'd1);
    end
    exp_stall += 4;
    check("bp_stall", 32'(Stall_cnt), 32'(exp_stall));
    Rsp_ready = 1'b1;
    #1 check("bp_release_ready", 32'(Req_ready), 32'd1);
    tick();
    check("bp_new_a", A, 32'h1234_5678);
    check("bp_new_b", B, 32'hDEAD_BEEF);
    check("bp_new_rsp", 32'(Rsp_valid), 32'd1);

    // Same register on both ports.
    Rs = 5'd9; Rt = 5'd9;
    tick();
    check("same_a", A, 32'hDEAD_BEEF);
    check("same_b", B, 32'hDEAD_BEEF);

    // Issue and write-back of r3 on the same edge: set wins.
    Req_valid = 1'b0; Iss_valid = 1'b1; Iss_rd = 5'd3;
    Wb_valid = 1'b1; Wb_rd = 5'd3; Wb_data = 32'h0BAD_0003;
    tick();
    Iss_valid = 1'b0; Wb_valid = 1'b0;
    Req_valid = 1'b1; Rs = 5'd3; Rt = 5'd0;
    #1 check("r3_busy_ready", 32'(Req_ready), 32'd0);
    Req_valid = 1'b0; Iss_valid = 1'b1; Iss_rd = 5'd0;
    tick();
    Iss_valid = 1'b0;
    Req_valid = 1'b1; Rs = 5'd0; Rt = 5'd0;
    #1 check("iss0_ready", 32'(Req_ready), 32'd1);
    tick();
    check("iss0_a", A, 32'h0);
    check("iss0_b", B, 32'h0);

    // Write-back to a non-busy register: forwarded or blocked depending on build.
    Rs = 5'd9; Rt = 5'd5; Wb_valid = 1'b1; Wb_rd = 5'd9; Wb_data = 32'h9999_0009;
`ifdef REG_READ_BYPASS_EN
    #1 check("wb_idle_ready_byp", 32'(Req_ready), 32'd1);
    tick();
    check("wb_idle_a_byp", A, 32'h9999_0009);
    check("wb_idle_b_byp", B, 32'h1234_5678);
`else
    #1 check("wb_idle_ready_nobyp", 32'(Req_ready), 32'd0);
    tick();
    exp_stall += 1;
`endif
    Wb_valid = 1'b0;

    // r3 is still busy; saturate the stall counter on it.
    Rs = 5'd3; Rt = 5'd0;
    #1 check("r3_still_busy", 32'(Req_ready), 32'd0);
    check("pre_sat_stall", 32'(Stall_cnt), 32'(exp_stall));
    for (int i = 0; i < 65540; i++) @(posedge Clk);
    #1 check("sat_stall", 32'(Stall_cnt), 32'h0000_FFFF);

    // Clear mid-stall.
    Clr = 1'b1;
    #1 check("clr_ready", 32'(Req_ready), 32'd0);
    tick();
    Clr = 1'b0;
    check("clr_stall", 32'(Stall_cnt), 32'd0);
    check("clr_rsp_valid", 32'(Rsp_valid), 32'd0);
    check("clr_a", A, 32'h0);
    #1 check("clr_busy_ready", 32'(Req_ready), 32'd1);
    tick();
    check("post_clr_a", A, 32'h3333_3333);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
